// File: rtl/rom_region_packer.sv
// Packs one ioctl download window into BYTES-wide dpram words, MSB first,
// and reports busy/done/error for the region so the core can be held off.
module rom_region_packer #(
    parameter logic [24:0] BASE      = 25'h000000,
    parameter int          SIZE_LOG2 = 15,
    parameter int          BYTES     = 2,
    parameter logic [7:0]  INDEX     = 8'd0,
    parameter int          AW        = SIZE_LOG2 - $clog2(BYTES)
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              o_wr,
    output logic [AW-1:0]     o_addr,
    output logic [8*BYTES-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int DW = 8 * BYTES;
    localparam int LW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [25:0] LIMIT = {1'b0, BASE} + (26'd1 << SIZE_LOG2);
    localparam logic [24:0] LAST = 25'((26'd1 << SIZE_LOG2) - 26'd1);
    localparam logic [LW-1:0] LANE_MAX = LW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t state, state_nx, st_base;

    logic          dl_q;
    logic [DW-1:0] acc;
    logic [LW-1:0] exp_lane;
    logic [AW-1:0] cur_word;
    logic          err;

    logic [24:0]   offset;
    logic          in_win, idx_ok, hit, dl_rise;
    logic [LW-1:0] lane, exp_base;
    logic [AW-1:0] word;
    logic [DW-1:0] acc_base, acc_sh;
    logic          in_seq, accept, seq_err, word_end, load_abort;

    assign offset  = ioctl_addr - BASE;
    assign in_win  = ({1'b0, ioctl_addr} >= {1'b0, BASE}) &&
                     ({1'b0, ioctl_addr} < LIMIT);
    assign idx_ok  = (ioctl_index == INDEX);
    assign hit     = ioctl_wr & ioctl_download & idx_ok & in_win;
    assign dl_rise = ioctl_download & ~dl_q & idx_ok;
    assign lane    = (BYTES == 1) ? '0 : offset[LW-1:0];
    assign word    = AW'(offset >> $clog2(BYTES));

    // A new download clears everything first; the same-cycle byte then sees a clean slate.
    assign acc_base = dl_rise ? '0 : acc;
    assign exp_base = dl_rise ? '0 : exp_lane;
    assign st_base  = dl_rise ? LOAD : state;

    // Mid-word bytes must also belong to the word that was started.
    assign in_seq   = (lane == exp_base) &&
                      ((exp_base == '0) || (word == cur_word));
    assign accept   = hit && (in_seq || (lane == '0));
    assign seq_err  = hit && !in_seq;
    assign acc_sh   = ((in_seq ? acc_base : '0) << 8) | DW'(ioctl_dout);
    assign word_end = accept && (lane == LANE_MAX);
    assign load_abort = (st_base == LOAD) && !ioctl_download;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = st_base;
        unique case (st_base)
            IDLE: if (hit) state_nx = LOAD;
            LOAD: begin
                if (hit && (offset == LAST)) state_nx = DONE;
                else if (!ioctl_download)    state_nx = IDLE;
            end
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == LOAD);
        o_done = (state == DONE);
        o_err  = err;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dl_q     <= 1'b0;
            acc      <= '0;
            exp_lane <= '0;
            cur_word <= '0;
            err      <= 1'b0;
            o_wr     <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
        end else begin
            dl_q <= ioctl_download;
            err  <= (dl_rise ? 1'b0 : err) | seq_err | load_abort;
            o_wr <= word_end;
            if (accept) begin
                acc      <= acc_sh;
                exp_lane <= word_end ? '0 : lane + 1'b1;
                if (lane == '0) cur_word <= word;
            end else if (seq_err) begin
                acc      <= '0;
                exp_lane <= '0;
            end else begin
                acc      <= acc_base;
                exp_lane <= exp_base;
            end
            if (word_end) begin
                o_addr <= word;
                o_data <= acc_sh;
            end
        end
    end

endmodule

// File: tb/tb_rom_region_packer.sv
// Directed bench for rom_region_packer: a 2-byte 32 KiB region and a
// 4-byte 16-byte region share one ioctl stream.
module tb_rom_region_packer;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        ioctl_download, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;

    logic        a_wr, a_busy, a_done, a_err;
    logic [13:0] a_addr;
    logic [15:0] a_data;
    logic        b_wr, b_busy, b_done, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_data;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    rom_region_packer #(
        .BASE(25'h040000), .SIZE_LOG2(15), .BYTES(2), .INDEX(8'd0)
    ) dut_a (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .o_wr(a_wr), .o_addr(a_addr), .o_data(a_data),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
    );

    rom_region_packer #(
        .BASE(25'h000000), .SIZE_LOG2(4), .BYTES(4), .INDEX(8'd0)
    ) dut_b (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .o_wr(b_wr), .o_addr(b_addr), .o_data(b_data),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        logic        wr;
        logic [1:0]  oaddr;
        logic [31:0] odata;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic send(input logic [7:0] idx, input logic [24:0] addr,
                        input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{25'd0,  8'h00, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[1]  = '{25'd1,  8'h01, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[2]  = '{25'd2,  8'h02, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[3]  = '{25'd3,  8'h03, 1'b1, 2'd0, 32'h00010203, 1'b1, 1'b0};
        tbl[4]  = '{25'd4,  8'h04, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[5]  = '{25'd5,  8'h05, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[6]  = '{25'd6,  8'h06, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[7]  = '{25'd7,  8'h07, 1'b1, 2'd1, 32'h04050607, 1'b1, 1'b0};
        tbl[8]  = '{25'd8,  8'h08, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[9]  = '{25'd9,  8'h09, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[10] = '{25'd10, 8'h0A, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[11] = '{25'd11, 8'h0B, 1'b1, 2'd2, 32'h08090A0B, 1'b1, 1'b0};
        tbl[12] = '{25'd12, 8'h0C, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[13] = '{25'd13, 8'h0D, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[14] = '{25'd14, 8'h0E, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0};
        tbl[15] = '{25'd15, 8'h0F, 1'b1, 2'd3, 32'h0C0D0E0F, 1'b0, 1'b1};

        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();

        chk("rst_a_flags", {a_wr, a_busy, a_done, a_err}, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_flags", {b_wr, b_busy, b_done, b_err}, 0);
        chk("rst_b_data", b_data, 0);
        rst_n = 1'b1;
        tick();

        // two-byte word packing
        ioctl_download = 1'b1;
        tick();
        chk("rise_a_busy", a_busy, 1);
        chk("rise_b_busy", b_busy, 1);
        send(8'd0, 25'h040000, 8'h12);
        chk("a_first_no_wr", a_wr, 0);
        send(8'd0, 25'h040001, 8'h34);
        chk("a_w0_wr", a_wr, 1);
        chk("a_w0_addr", a_addr, 0);
        chk("a_w0_data", a_data, 16'h1234);
        tick();
        chk("a_wr_one_cycle", a_wr, 0);

        // lane sequence error then a fresh word start
        send(8'd0, 25'h040000, 8'h56);
        chk("seq_w0_no_wr", a_wr, 0);
        send(8'd0, 25'h040003, 8'h78);
        chk("seq_bad_no_wr", a_wr, 0);
        chk("seq_err", a_err, 1);
        send(8'd0, 25'h040002, 8'h9A);
        chk("seq_restart_no_wr", a_wr, 0);
        send(8'd0, 25'h040003, 8'hBC);
        chk("seq_w1_wr", a_wr, 1);
        chk("seq_w1_addr", a_addr, 1);
        chk("seq_w1_data", a_data, 16'h9ABC);

        // abort mid-load
        ioctl_download = 1'b0;
        tick();
        chk("abort_a_flags", {a_busy, a_done, a_err}, 3'b001);
        chk("abort_b_flags", {b_busy, b_done, b_err}, 3'b001);

        // four-byte region streamed from the table
        ioctl_download = 1'b1;
        tick();
        chk("rise2_b_busy_err", {b_busy, b_err}, 2'b10);
        chk("rise2_a_busy_err", {a_busy, a_err}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            send(8'd0, tbl[i].addr, tbl[i].din);
            chk($sformatf("tbl%0d_wr", i), b_wr, tbl[i].wr);
            if (tbl[i].wr) begin
                chk($sformatf("tbl%0d_addr", i), b_addr, tbl[i].oaddr);
                chk($sformatf("tbl%0d_data", i), b_data, tbl[i].odata);
            end
            chk($sformatf("tbl%0d_busy", i), b_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), b_done, tbl[i].done);
        end
        tick();
        chk("b_done_hold", {b_wr, b_busy, b_done, b_err}, 4'b0010);

        // download aborted after 100 bytes of region a
        for (int i = 0; i < 100; i++) begin
            send(8'd0, 25'h040000 + 25'(i), 8'(i));
            chk($sformatf("part%0d_busy", i), a_busy, 1);
        end
        chk("part_no_err", a_err, 0);
        ioctl_download = 1'b0;
        tick();
        chk("part_a_flags", {a_busy, a_done, a_err}, 3'b001);
        chk("part_b_flags", {b_busy, b_done, b_err}, 3'b010);

        // out-of-window and foreign-index bytes
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        tick();
        send(8'd0, 25'h03FFFF, 8'hEE);
        chk("below_no_wr", a_wr, 0);
        send(8'd0, 25'h048000, 8'hEE);
        chk("above_no_wr", a_wr, 0);
        send(8'd254, 25'h040000, 8'hEE);
        chk("idx0_no_wr", a_wr, 0);
        send(8'd254, 25'h040001, 8'hEE);
        chk("idx1_no_wr", a_wr, 0);
        chk("win_a_idle", {a_busy, a_done}, 2'b00);
        chk("win_b_done", b_done, 1);
        ioctl_download = 1'b0;
        tick();

        // reset in the middle of a word
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        send(8'd0, 25'd0, 8'hAA);
        chk("pre_rst_no_wr", b_wr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_b", {b_wr, b_busy, b_done, b_err}, 0);
        chk("async_rst_data", b_data, 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", b_busy, 1);
        send(8'd0, 25'd0, 8'h11);
        chk("post_b0_no_wr", b_wr, 0);
        send(8'd0, 25'd1, 8'h22);
        chk("post_b1_no_wr", b_wr, 0);
        send(8'd0, 25'd2, 8'h33);
        chk("post_b2_no_wr", b_wr, 0);
        send(8'd0, 25'd3, 8'h44);
        chk("post_wr", b_wr, 1);
        chk("post_addr", b_addr, 0);
        chk("post_data", b_data, 32'h11223344);
        tick();
        chk("post_wr_end", b_wr, 0);
        ioctl_download = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
